control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
// - State register and sequencing glue for the multi-cycle control unit: captures NS[3:0] from the PLA
//   each cycle and returns CurrentState[3:0] to it; sits between the PLA and the datapath.
// - Adds memory wait-state stalling, a global hold, illegal-state recovery and a memory timeout.
// - Gates the architectural write enables (PC, IR, register file) so a stalled cycle never commits.
// - Counts cycles and retired instructions.
// PARAMETERS
// - CNT_W       32   width of cycle_cnt / instr_cnt (wrap-around counters)
// - WAIT_LIMIT  64   consecutive memory-wait cycles that raise a timeout (legal range 1..255)
// PORTS
// - clk            in   1      rising-edge clock
// - rst_n          in   1      synchronous active-low reset
// - ns             in   4      {NS3,NS2,NS1,NS0} from PLA
// - cur_state      out  4      CurrentState to PLA; registered
// - mem_ready      in   1      memory access completes this cycle
// - hold           in   1      global stall request
// - pc_write       in   1      PCWrite from PLA
// - pc_write_cond  in   1      PCWriteCond from PLA
// - alu_zero       in   1      ALU zero flag
// - ir_write       in   1      IRWrite from PLA
// - reg_write      in   1      RegWrite from PLA
// - pc_en          out  1      gated PC load enable
// - ir_en          out  1      gated IR load enable
// - rf_we          out  1      gated register-file write enable
// - retired        out  1      1-cycle pulse: an instruction completed; registered
// - cycle_cnt      out  CNT_W  cycles since reset
// - instr_cnt      out  CNT_W  instructions retired since reset
// - err_illegal    out  1      sticky: PLA produced ns > 9
// - err_timeout    out  1      sticky: memory wait exceeded WAIT_LIMIT
// - clr_err        in   1      clears both sticky flags
// BEHAVIOUR
// - Reset (rst_n=0 at an edge): cur_state=0 (FETCH); retired, err_*, counters and the wait counter are 0.
//   Reset mid-instruction abandons it and does not pulse retired.
// - States 0..9: FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC, RCOMPL, BRANCH, JUMP.
//   Memory-access states are 0, 3 and 5.
// - mem_wait = (cur_state in {0,3,5}) & ~mem_ready
// - stall = mem_wait | hold; advance = ~stall
// - Next state, in priority order:
//   - timeout -> 0
//   - stall -> hold cur_state
//   - ns > 9 -> 0, and set err_illegal
//   - otherwise -> ns
// - Wait counter:
//   - increments on each mem_wait cycle (hold alone does not count); clears on any cycle without mem_wait.
//   - timeout fires when the counter already equals WAIT_LIMIT-1 and mem_wait is still 1.
//   - On timeout: err_timeout set; state forced to 0; pc_en, ir_en and rf_we forced to 0 that cycle.
// - Enables are combinational, same cycle; all are 0 whenever stall or timeout is true:
//   - pc_en = advance & (pc_write | (pc_write_cond & alu_zero))
//   - ir_en = advance & ir_write
//   - rf_we = advance & reg_write
// - retired:
//   - is 1 for exactly one cycle following an advancing edge where cur_state != 0 and the next state is 0
//     (and that next state is not due to the illegal or timeout path).
//   - instr_cnt increments on that same edge.
// - cycle_cnt increments on every non-reset edge. Both counters wrap modulo 2^CNT_W.
// - Sticky flags: if clr_err and a set event occur on the same edge, set wins.
// STRUCTURE
// - Package ctrl_pkg holds:
//   - STATE_W=4, the ST_FETCH..ST_JUMP constants, ST_MAX=9
//   - function is_mem_state(state)
// - Sub-module event_counter (param W; ports clk, rst_n, inc, q) is instantiated for cycle_cnt and instr_cnt.
// - Everything else lives in the top module: state register, wait counter, gating.
// TESTING
// - Reset, then release with ns=1 and mem_ready=1 -> cur_state 0->1; cycle_cnt=1; retired=0.
// - In FETCH with mem_ready=0 for 3 cycles, ir_write=pc_write=1 -> cur_state stays 0, ir_en=pc_en=0;
//   on mem_ready=1 -> both enables=1 and the state advances.
// - R-type sequence 0,1,6,7,0 with mem_ready=1 -> retired pulses exactly one cycle after the 7->0 edge;
//   instr_cnt=1.
// - In state 8 with pc_write_cond=1: alu_zero=0 -> pc_en=0; alu_zero=1 -> pc_en=1.
//   With hold=1 -> pc_en=0 and the state is held.
// - ns=4'b1100 from state 1 -> next cur_state=0; err_illegal=1; no retired pulse;
//   clr_err=1 on a clean cycle -> flag clears.
// - WAIT_LIMIT=4, state 3 with mem_ready=0 -> after 4 wait cycles state=0 and err_timeout=1;
//   rst_n=0 then clears it and all counters.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control sequencer.
//   STATE_W      width of the PLA state encoding
//   state_e      FETCH..JUMP state encodings (0..9)
//   ST_MAX       highest legal state encoding
//   is_mem_state true for states that issue a memory access (FETCH, MEMREAD, MEMWRITE)
package ctrl_pkg;

   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEMADDR  = 4'd2,
      ST_MEMREAD  = 4'd3,
      ST_MEMWB    = 4'd4,
      ST_MEMWRITE = 4'd5,
      ST_EXEC     = 4'd6,
      ST_RCOMPL   = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9
   } state_e;

   localparam logic [STATE_W-1:0] ST_MAX = 4'd9;

   function automatic logic is_mem_state(input logic [STATE_W-1:0] state);
      return (state == ST_FETCH) || (state == ST_MEMREAD) || (state == ST_MEMWRITE);
   endfunction

endpackage

// File: rtl/event_counter.sv
// event_counter: wrap-around event counter with synchronous active-low reset.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears q
//   inc    count enable, q advances by one on each edge where it is high
//   q      current count, wraps modulo 2^W
module event_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc) cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign q = cnt_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: state register and sequencing glue between the control PLA and datapath.
//   clk, rst_n         clock and synchronous active-low reset
//   ns / cur_state     next state from the PLA / registered current state back to it
//   mem_ready, hold    memory completion and global stall request
//   pc_write, pc_write_cond, alu_zero, ir_write, reg_write   raw PLA enables and ALU flag
//   pc_en, ir_en, rf_we                                       stall-gated enables (combinational)
//   retired            registered one-cycle pulse per completed instruction
//   cycle_cnt, instr_cnt  cycles since reset / instructions retired since reset
//   err_illegal, err_timeout, clr_err   sticky error flags and their clear
// Handshake: in a memory-access state the access is pending until mem_ready is sampled high;
// every cycle with mem_ready low is a wait cycle in which nothing commits and the state holds.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int WAIT_LIMIT = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STATE_W-1:0] ns,
   output logic [STATE_W-1:0] cur_state,
   input  logic               mem_ready,
   input  logic               hold,
   input  logic               pc_write,
   input  logic               pc_write_cond,
   input  logic               alu_zero,
   input  logic               ir_write,
   input  logic               reg_write,
   output logic               pc_en,
   output logic               ir_en,
   output logic               rf_we,
   output logic               retired,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [CNT_W-1:0]   instr_cnt,
   output logic               err_illegal,
   output logic               err_timeout,
   input  logic               clr_err
);

   localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

   state_e     state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       retired_q, err_illegal_q, err_timeout_q;

   logic mem_wait, stall, advance, timeout, illegal_evt, retire_evt;

   always_comb begin
      mem_wait    = is_mem_state(state_q) & ~mem_ready;
      stall       = mem_wait | hold;
      advance     = ~stall;
      timeout     = mem_wait & (wait_cnt_q == WAIT_LAST);
      illegal_evt = 1'b0;
      retire_evt  = 1'b0;
      state_d     = state_q;
      wait_cnt_d  = '0;

      // The timer restarts after a timeout so the forced FETCH gets a full wait budget.
      if (mem_wait && !timeout) wait_cnt_d = wait_cnt_q + 8'd1;

      if (timeout) begin
         state_d = ST_FETCH;
      end else if (stall) begin
         state_d = state_q;
      end else if (ns > ST_MAX) begin
         state_d     = ST_FETCH;
         illegal_evt = 1'b1;
      end else begin
         state_d    = state_e'(ns);
         // Only a normal return to FETCH from a non-FETCH state completes an instruction.
         retire_evt = (state_q != ST_FETCH) && (ns == ST_FETCH);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_FETCH;
         wait_cnt_q    <= '0;
         retired_q     <= 1'b0;
         err_illegal_q <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         retired_q     <= retire_evt;
         // Set has priority over clear on the same edge.
         err_illegal_q <= illegal_evt | (err_illegal_q & ~clr_err);
         err_timeout_q <= timeout     | (err_timeout_q & ~clr_err);
      end
   end

   // timeout implies mem_wait, so advance already masks the enables in that cycle.
   assign pc_en = advance & (pc_write | (pc_write_cond & alu_zero));
   assign ir_en = advance & ir_write;
   assign rf_we = advance & reg_write;

   assign cur_state   = state_q;
   assign retired     = retired_q;
   assign err_illegal = err_illegal_q;
   assign err_timeout = err_timeout_q;

   event_counter #(.W(CNT_W)) u_cycle_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .q     (cycle_cnt)
   );

   event_counter #(.W(CNT_W)) u_instr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire_evt),
      .q     (instr_cnt)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed self-checking bench for control_sequencer (WAIT_LIMIT=4).
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  ns;
   logic [3:0]  cur_state;
   logic        mem_ready, hold, pc_write, pc_write_cond, alu_zero, ir_write, reg_write;
   logic        pc_en, ir_en, rf_we, retired;
   logic [31:0] cycle_cnt, instr_cnt;
   logic        err_illegal, err_timeout, clr_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   control_sequencer #(.CNT_W(32), .WAIT_LIMIT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ns            (ns),
      .cur_state     (cur_state),
      .mem_ready     (mem_ready),
      .hold          (hold),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .alu_zero      (alu_zero),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .pc_en         (pc_en),
      .ir_en         (ir_en),
      .rf_we         (rf_we),
      .retired       (retired),
      .cycle_cnt     (cycle_cnt),
      .instr_cnt     (instr_cnt),
      .err_illegal   (err_illegal),
      .err_timeout   (err_timeout),
      .clr_err       (clr_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change, before the next edge.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0; ns = 4'd1; mem_ready = 1'b1; hold = 1'b0;
      pc_write = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
      ir_write = 1'b0; reg_write = 1'b0; clr_err = 1'b0;

      // Reset state
      step(); step();
      chk("rst_state", 32'(cur_state), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_cycle", cycle_cnt, 32'd0);
      chk("rst_instr", instr_cnt, 32'd0);
      chk("rst_errs", {30'd0, err_illegal, err_timeout}, 32'd0);

      // Release: 0 -> 1
      rst_n = 1'b1;
      step();
      chk("rel_state", 32'(cur_state), 32'd1);
      chk("rel_cycle", cycle_cnt, 32'd1);
      chk("rel_retired", 32'(retired), 32'd0);

      // Reset from DECODE abandons the instruction without retiring it
      rst_n = 1'b0; ns = 4'd0;
      step();
      chk("rst2_state", 32'(cur_state), 32'd0);
      chk("rst2_retired", 32'(retired), 32'd0);
      rst_n = 1'b1;

      // FETCH wait states
      ns = 4'd1; mem_ready = 1'b0; ir_write = 1'b1; pc_write = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("fw_ir_en", 32'(ir_en), 32'd0);
         chk("fw_pc_en", 32'(pc_en), 32'd0);
         step();
         chk("fw_state", 32'(cur_state), 32'd0);
      end
      mem_ready = 1'b1;
      settle();
      chk("fr_ir_en", 32'(ir_en), 32'd1);
      chk("fr_pc_en", 32'(pc_en), 32'd1);
      step();
      chk("fr_state", 32'(cur_state), 32'd1);
      chk("fr_cycle", cycle_cnt, 32'd4);
      chk("fr_err_to", 32'(err_timeout), 32'd0);
      ir_write = 1'b0; pc_write = 1'b0;

      // R-type 1 -> 6 -> 7 -> 0
      ns = 4'd6; step();
      chk("r_exec", 32'(cur_state), 32'd6);
      ns = 4'd7; step();
      chk("r_rcompl", 32'(cur_state), 32'd7);
      reg_write = 1'b1; ns = 4'd0;
      settle();
      chk("r_rf_we", 32'(rf_we), 32'd1);
      chk("r_pre_retired", 32'(retired), 32'd0);
      step();
      reg_write = 1'b0;
      chk("r_fetch", 32'(cur_state), 32'd0);
      chk("r_retired", 32'(retired), 32'd1);
      chk("r_instr", instr_cnt, 32'd1);
      ns = 4'd1; step();
      chk("r_retired_off", 32'(retired), 32'd0);
      chk("r_instr_hold", instr_cnt, 32'd1);

      // Branch: conditional PC enable and hold
      ns = 4'd8; step();
      chk("b_state", 32'(cur_state), 32'd8);
      pc_write_cond = 1'b1; alu_zero = 1'b0; ns = 4'd0;
      settle();
      chk("b_nz_pc_en", 32'(pc_en), 32'd0);
      alu_zero = 1'b1;
      settle();
      chk("b_z_pc_en", 32'(pc_en), 32'd1);
      hold = 1'b1;
      settle();
      chk("b_hold_pc_en", 32'(pc_en), 32'd0);
      step();
      chk("b_hold_state", 32'(cur_state), 32'd8);
      chk("b_hold_retired", 32'(retired), 32'd0);
      hold = 1'b0; pc_write_cond = 1'b0; alu_zero = 1'b0;
      step();
      chk("b_fetch", 32'(cur_state), 32'd0);
      chk("b_retired", 32'(retired), 32'd1);
      chk("b_instr", instr_cnt, 32'd2);

      // Illegal next state
      ns = 4'd1; step();
      chk("il_decode", 32'(cur_state), 32'd1);
      ns = 4'b1100; step();
      chk("il_state", 32'(cur_state), 32'd0);
      chk("il_flag", 32'(err_illegal), 32'd1);
      chk("il_retired", 32'(retired), 32'd0);
      chk("il_instr", instr_cnt, 32'd2);
      ns = 4'd1; clr_err = 1'b1; step();
      clr_err = 1'b0;
      chk("il_clr", 32'(err_illegal), 32'd0);
      chk("il_clr_state", 32'(cur_state), 32'd1);
      // Set wins over clear on the same edge
      ns = 4'd15; clr_err = 1'b1; step();
      chk("il_set_wins", 32'(err_illegal), 32'd1);
      ns = 4'd1; step();
      clr_err = 1'b0;
      chk("il_clr2", 32'(err_illegal), 32'd0);

      // Memory timeout in MEMREAD; a hold-only cycle clears the wait counter
      ns = 4'd2; step();
      ns = 4'd3; step();
      chk("to_memread", 32'(cur_state), 32'd3);
      ns = 4'd4; mem_ready = 1'b0;
      step(); step();
      chk("to_wait2", 32'(cur_state), 32'd3);
      mem_ready = 1'b1; hold = 1'b1;
      step();
      chk("to_hold", 32'(cur_state), 32'd3);
      hold = 1'b0; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("to_wait", 32'(cur_state), 32'd3);
         chk("to_noflag", 32'(err_timeout), 32'd0);
      end
      pc_write = 1'b1;
      settle();
      chk("to_pc_en", 32'(pc_en), 32'd0);
      step();
      pc_write = 1'b0;
      chk("to_state", 32'(cur_state), 32'd0);
      chk("to_flag", 32'(err_timeout), 32'd1);
      chk("to_retired", 32'(retired), 32'd0);

      // Reset clears flag and counters
      mem_ready = 1'b1; rst_n = 1'b0;
      step();
      chk("fin_err_to", 32'(err_timeout), 32'd0);
      chk("fin_cycle", cycle_cnt, 32'd0);
      chk("fin_instr", instr_cnt, 32'd0);
      chk("fin_state", 32'(cur_state), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
